mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Sequences every LC-3b memory access through the MAR and the memory interface.
- Arbitrates between the instruction-fetch requester and the data (LDB/LDW/STB/STW) requester.
- Drives the MAR load strobe, size and write attributes, memory enable and byte-lane write enables.
- Returns read data or an error to the winning requester; sits between the control unit and the MAR/memory path.

Parameters:
MEM_TIMEOUT, 15, max cycles in MEM_WAIT without mem_ready before bus error; 0 disables timeout
CNT_W, 4, width of timeout counter; must hold MEM_TIMEOUT

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held until if_done
if_addr  in  16  fetch address (word access)
if_done  out  1  one-cycle completion pulse for fetch
if_err  out  1  valid with if_done: unaligned or timeout
if_rdata  out  16  fetched word, valid with if_done
dm_req  in  1  data request; held until dm_done
dm_addr  in  16  data address
dm_size  in  1  0 = byte, 1 = word
dm_write  in  1  1 = store, 0 = load
dm_wdata  in  16  store data (byte store uses [7:0])
dm_done  out  1  one-cycle completion pulse for data
dm_err  out  1  valid with dm_done: unaligned or timeout
dm_rdata  out  16  load data, valid with dm_done; byte loads zero-extended
LD_MAR  out  1  MAR load strobe
mar_in  out  16  address to MAR
mar_size  out  1  size attribute to MAR
mar_write  out  1  write attribute to MAR
mem_en  out  1  memory access enable
mem_we_lo  out  1  write enable, byte lane [7:0]
mem_we_hi  out  1  write enable, byte lane [15:8]
mem_wdata  out  16  write data to memory
mem_rdata  in  16  read data from memory
mem_ready  in  1  memory completion (R)
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, LOAD, MEM_WAIT, RESP. Reset forces IDLE.
- Reset clears every output, the latched request, owner and timeout counter to 0.
- Reset mid-operation abandons the access: no done pulse; mem_en is 0 from the next cycle.
- IDLE: sample requests each cycle.
  - dm_req has fixed priority over if_req; simultaneous requests grant data and leave fetch pending.
  - Latch owner, address, size (fetch is always word), write flag and write data.
- Alignment check is made in IDLE at grant time.
  - Word access (fetch, or dm_size = 1) with addr[0] = 1 goes directly to RESP with err = 1 and rdata = 0.
  - No LD_MAR and no mem_en for an unaligned access.
- LOAD, exactly one cycle:
  - LD_MAR = 1; mar_in, mar_size and mar_write driven from the latched request.
  - mar_in/size/write are registered and held stable from LOAD until leaving MEM_WAIT.
- MEM_WAIT:
  - mem_en = 1.
  - Store enables: word store drives mem_we_lo = mem_we_hi = 1. Byte store drives mem_we_hi = addr[0] and mem_we_lo = ~addr[0].
  - Store data: mem_wdata = wdata for a word, {wdata[7:0], wdata[7:0]} for a byte. Loads drive both enables 0.
  - Counter increments each MEM_WAIT cycle.
  - mem_ready = 1: capture data and go to RESP with err = 0.
    - Word read takes mem_rdata.
    - Byte read takes {8'h00, addr[0] ? mem_rdata[15:8] : mem_rdata[7:0]}.
    - Store returns rdata = 0.
  - Timeout: MEM_TIMEOUT != 0, the counter reaches MEM_TIMEOUT and mem_ready = 0 goes to RESP with err = 1, rdata = 0.
  - mem_ready on the final allowed cycle counts as success.
- RESP, one cycle:
  - Owner's done = 1 with err/rdata; the other requester's done stays 0.
  - Next state is IDLE.
  - Requester drops req at the edge ending RESP.
  - One IDLE cycle between back-to-back accesses is mandatory.
- Latency: request seen in IDLE cycle 0 gives LD_MAR in cycle 1 and mem_en from cycle 2. With mem_ready in cycle 2, done comes in cycle 3, so the minimum is 3 cycles. Each extra wait cycle adds 1. Unaligned: done in cycle 1.
- Outside their active states, LD_MAR, mem_en, mem_we_* and the done pulses are 0.
- mem_ready outside MEM_WAIT is ignored.
- Requests arriving while busy are not granted until IDLE.
- If a requester drops req mid-access, the access completes anyway.

Test Plan:
- Fetch, if_addr = 16'h3000, mem_ready in first MEM_WAIT cycle, mem_rdata = 16'h1234 -> LD_MAR pulse in cycle 1 with mar_in = 16'h3000, mar_size = 1; if_done in cycle 3, if_rdata = 16'h1234, if_err = 0.
- if_req and dm_req in the same cycle, dm LDW at 16'h4002 -> data access first, dm_done, one IDLE cycle, then fetch serviced; never both done in one cycle.
- STB at 16'h4001, dm_wdata = 16'h00AB -> mem_we_hi = 1, mem_we_lo = 0, mem_wdata = 16'hABAB; LDB at 16'h4001 with mem_rdata = 16'hAB00 -> dm_rdata = 16'h00AB.
- LDW at 16'h4003 -> dm_done with dm_err = 1 in cycle 1; LD_MAR and mem_en never asserted.
- mem_ready held 0, MEM_TIMEOUT = 15 -> 15 cycles of mem_en, then dm_done with dm_err = 1, dm_rdata = 0; repeat with ready on cycle 15 -> success.
- reset asserted during MEM_WAIT -> next cycle all outputs 0, busy = 0, no done pulse; a new request afterwards completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer for the LC-3b datapath: arbitrates fetch vs. data
// requests, drives MAR load and memory strobes, and returns data/err to the owner.
module mem_access_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_done,
  output logic        if_err,
  output logic [15:0] if_rdata,
  input  logic        dm_req,
  input  logic [15:0] dm_addr,
  input  logic        dm_size,
  input  logic        dm_write,
  input  logic [15:0] dm_wdata,
  output logic        dm_done,
  output logic        dm_err,
  output logic [15:0] dm_rdata,
  output logic        LD_MAR,
  output logic [15:0] mar_in,
  output logic        mar_size,
  output logic        mar_write,
  output logic        mem_en,
  output logic        mem_we_lo,
  output logic        mem_we_hi,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, LOAD, MEM_WAIT, RESP} state_t;

  localparam logic [CNT_W:0] TIMEOUT_V = (CNT_W+1)'(MEM_TIMEOUT);

  state_t           state_q;
  logic             owner_q;   // 1 = data requester, 0 = fetch
  logic [15:0]      addr_q;
  logic             size_q;
  logic             write_q;
  logic [15:0]      wdata_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ld_mar_q, mem_en_q, we_lo_q, we_hi_q;
  logic [15:0]      mar_in_q, mem_wdata_q, rdata_q;
  logic             mar_size_q, mar_write_q;
  logic             if_done_q, dm_done_q, err_q;

  logic [CNT_W:0]   cnt_next_d;
  logic             timeout_d;
  logic             grant_dm_d;
  logic [15:0]      grant_addr_d;
  logic             grant_size_d;

  always_comb begin
    cnt_next_d   = {1'b0, cnt_q} + (CNT_W+1)'(1);
    timeout_d    = (MEM_TIMEOUT != 0) && (cnt_next_d == TIMEOUT_V);
    grant_dm_d   = dm_req;
    grant_addr_d = dm_req ? dm_addr : if_addr;
    grant_size_d = dm_req ? dm_size : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      addr_q      <= '0;
      size_q      <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      ld_mar_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      we_lo_q     <= 1'b0;
      we_hi_q     <= 1'b0;
      mar_in_q    <= '0;
      mar_size_q  <= 1'b0;
      mar_write_q <= 1'b0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
    end else begin
      ld_mar_q  <= 1'b0;
      mem_en_q  <= 1'b0;
      we_lo_q   <= 1'b0;
      we_hi_q   <= 1'b0;
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dm_req || if_req) begin
            owner_q <= grant_dm_d;
            addr_q  <= grant_addr_d;
            size_q  <= grant_size_d;
            write_q <= grant_dm_d & dm_write;
            wdata_q <= dm_wdata;
            // Misaligned word accesses never reach the MAR or memory.
            if (grant_size_d && grant_addr_d[0]) begin
              state_q   <= RESP;
              err_q     <= 1'b1;
              rdata_q   <= '0;
              dm_done_q <= grant_dm_d;
              if_done_q <= ~grant_dm_d;
            end else begin
              state_q     <= LOAD;
              ld_mar_q    <= 1'b1;
              mar_in_q    <= grant_addr_d;
              mar_size_q  <= grant_size_d;
              mar_write_q <= grant_dm_d & dm_write;
            end
          end
        end
        LOAD: begin
          state_q     <= MEM_WAIT;
          cnt_q       <= '0;
          mem_en_q    <= 1'b1;
          we_lo_q     <= write_q & (size_q | ~addr_q[0]);
          we_hi_q     <= write_q & (size_q |  addr_q[0]);
          mem_wdata_q <= size_q ? wdata_q : {wdata_q[7:0], wdata_q[7:0]};
        end
        MEM_WAIT: begin
          cnt_q <= cnt_next_d[CNT_W-1:0];
          if (mem_ready || timeout_d) begin
            state_q   <= RESP;
            err_q     <= ~mem_ready;
            dm_done_q <= owner_q;
            if_done_q <= ~owner_q;
            if (!mem_ready || write_q)
              rdata_q <= '0;
            else if (size_q)
              rdata_q <= mem_rdata;
            else
              rdata_q <= {8'h00, addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0]};
          end else begin
            mem_en_q <= 1'b1;
            we_lo_q  <= we_lo_q;
            we_hi_q  <= we_hi_q;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign LD_MAR    = ld_mar_q;
  assign mar_in    = mar_in_q;
  assign mar_size  = mar_size_q;
  assign mar_write = mar_write_q;
  assign mem_en    = mem_en_q;
  assign mem_we_lo = we_lo_q;
  assign mem_we_hi = we_hi_q;
  assign mem_wdata = mem_wdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign if_err    = if_done_q & err_q;
  assign dm_err    = dm_done_q & err_q;
  assign if_rdata  = if_done_q ? rdata_q : 16'h0000;
  assign dm_rdata  = dm_done_q ? rdata_q : 16'h0000;
  assign busy      = (state_q != IDLE);

endmodule
